// File: rtl/alu_ctrl_exec.sv
// Execute-stage unit: ALU-control decode, registered single-cycle ALU and an
// iterative shift-add multiplier behind a valid/ready input handshake.
module alu_ctrl_exec #(
    parameter int WIDTH      = 64,
    parameter int RADIX_BITS = 1,
    parameter int MUL_EN     = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       alu_op,
    input  logic [3:0]       funct,
    input  logic             m_ext,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic [3:0]       operation,
    output logic             illegal,
    output logic             busy
);

    localparam int STEPS = WIDTH / RADIX_BITS;
    localparam int SHW   = $clog2(WIDTH);
    localparam int CNTW  = $clog2(STEPS + 1);
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(STEPS - 1);

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SRL  = 4'b0100;
    localparam logic [3:0] OP_SRA  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLTU = 4'b1000;
    localparam logic [3:0] OP_MUL  = 4'b1001;
    localparam logic [3:0] OP_SLL  = 4'b1111;

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t           state_reg;
    logic             in_ready_reg;
    logic             busy_reg;
    logic             out_valid_reg;
    logic [WIDTH-1:0] result_reg;
    logic             zero_reg;
    logic [3:0]       operation_reg;
    logic             illegal_reg;

    logic [WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0] mcand_reg;
    logic [WIDTH-1:0] mplier_reg;
    logic [CNTW-1:0]  cnt_reg;

    logic [3:0]       dec_op;
    logic             dec_ill;
    logic [WIDTH-1:0] alu_res;
    logic [SHW-1:0]   shamt;

    assign shamt = b[SHW-1:0];

    // Decode ALUOp / funct / M-select into an internal op code.
    always_comb begin
        dec_op  = OP_AND;
        dec_ill = 1'b0;
        case (alu_op)
            2'b00: dec_op = OP_ADD;
            2'b01: dec_op = OP_SUB;
            2'b10: begin
                if (m_ext) begin
                    if (funct == 4'b0000 && MUL_EN != 0) dec_op = OP_MUL;
                    else                                 dec_ill = 1'b1;
                end else begin
                    case (funct)
                        4'b0000: dec_op = OP_ADD;
                        4'b1000: dec_op = OP_SUB;
                        4'b0111: dec_op = OP_AND;
                        4'b0110: dec_op = OP_OR;
                        4'b0100: dec_op = OP_XOR;
                        4'b0001: dec_op = OP_SLL;
                        4'b0101: dec_op = OP_SRL;
                        4'b1101: dec_op = OP_SRA;
                        4'b0010: dec_op = OP_SLT;
                        4'b0011: dec_op = OP_SLTU;
                        default: dec_ill = 1'b1;
                    endcase
                end
            end
            default: begin
                case (funct[2:0])
                    3'b000:  dec_op = OP_ADD;
                    3'b111:  dec_op = OP_AND;
                    3'b110:  dec_op = OP_OR;
                    3'b100:  dec_op = OP_XOR;
                    3'b001:  dec_op = OP_SLL;
                    3'b010:  dec_op = OP_SLT;
                    3'b011:  dec_op = OP_SLTU;
                    default: dec_op = funct[3] ? OP_SRA : OP_SRL;
                endcase
            end
        endcase
    end

    // Single-cycle datapath; illegal ops produce zero.
    always_comb begin
        alu_res = '0;
        if (!dec_ill) begin
            case (dec_op)
                OP_ADD:  alu_res = a + b;
                OP_SUB:  alu_res = a - b;
                OP_AND:  alu_res = a & b;
                OP_OR:   alu_res = a | b;
                OP_XOR:  alu_res = a ^ b;
                OP_SLL:  alu_res = a << shamt;
                OP_SRL:  alu_res = a >> shamt;
                OP_SRA:  alu_res = $signed(a) >>> shamt;
                OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
                OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, a < b};
                default: alu_res = '0;
            endcase
        end
    end

    // One multiplier step: add the shifted multiplicand for each set bit of
    // the current low slice of the multiplier.
    logic [WIDTH-1:0] psum [RADIX_BITS+1];
    assign psum[0] = acc_reg;
    generate
        for (genvar gi = 0; gi < RADIX_BITS; gi++) begin : g_pp
            assign psum[gi+1] = psum[gi] +
                (mplier_reg[gi] ? (mcand_reg << gi) : {WIDTH{1'b0}});
        end
    endgenerate

    // Control FSM, multiplier iteration and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            in_ready_reg  <= 1'b1;
            busy_reg      <= 1'b0;
            out_valid_reg <= 1'b0;
            result_reg    <= '0;
            zero_reg      <= 1'b0;
            operation_reg <= '0;
            illegal_reg   <= 1'b0;
            acc_reg       <= '0;
            mcand_reg     <= '0;
            mplier_reg    <= '0;
            cnt_reg       <= '0;
        end else begin
            out_valid_reg <= 1'b0;
            if (flush) begin
                // Drop any in-flight MUL; result keeps its last value.
                state_reg    <= S_IDLE;
                in_ready_reg <= 1'b1;
                busy_reg     <= 1'b0;
            end else begin
                case (state_reg)
                    S_IDLE: begin
                        if (in_valid && in_ready_reg) begin
                            if (!dec_ill && dec_op == OP_MUL) begin
                                state_reg    <= S_MUL;
                                in_ready_reg <= 1'b0;
                                busy_reg     <= 1'b1;
                                acc_reg      <= '0;
                                mcand_reg    <= a;
                                mplier_reg   <= b;
                                cnt_reg      <= CNT_LAST;
                            end else begin
                                out_valid_reg <= 1'b1;
                                result_reg    <= alu_res;
                                zero_reg      <= (alu_res == '0);
                                operation_reg <= dec_op;
                                illegal_reg   <= dec_ill;
                            end
                        end
                    end
                    default: begin
                        acc_reg    <= psum[RADIX_BITS];
                        mcand_reg  <= mcand_reg << RADIX_BITS;
                        mplier_reg <= mplier_reg >> RADIX_BITS;
                        cnt_reg    <= cnt_reg - 1'b1;
                        if (cnt_reg == '0) begin
                            state_reg     <= S_IDLE;
                            in_ready_reg  <= 1'b1;
                            busy_reg      <= 1'b0;
                            out_valid_reg <= 1'b1;
                            result_reg    <= psum[RADIX_BITS];
                            zero_reg      <= (psum[RADIX_BITS] == '0);
                            operation_reg <= OP_MUL;
                            illegal_reg   <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end

    assign in_ready  = in_ready_reg;
    assign busy      = busy_reg;
    assign out_valid = out_valid_reg;
    assign result    = result_reg;
    assign zero      = zero_reg;
    assign operation = operation_reg;
    assign illegal   = illegal_reg;

endmodule

// File: tb/tb_alu_ctrl_exec.sv
// Self-checking bench for alu_ctrl_exec: transaction-level reference model
// checked every cycle, plus directed vectors with literal expectations.
module tb_alu_ctrl_exec;

    localparam int W = 64;
    localparam int N = 64;

    logic          clk = 1'b0;
    logic          reset, flush, in_valid, m_ext;
    logic [1:0]    alu_op;
    logic [3:0]    funct;
    logic [W-1:0]  a, b;
    logic          in_ready, out_valid, zero, illegal, busy;
    logic [W-1:0]  result;
    logic [3:0]    operation;
    logic          n_in_ready, n_out_valid, n_zero, n_illegal, n_busy;
    logic [W-1:0]  n_result;
    logic [3:0]    n_operation;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_ctrl_exec #(.WIDTH(W), .RADIX_BITS(1), .MUL_EN(1)) dut (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
        .in_ready(in_ready), .alu_op(alu_op), .funct(funct), .m_ext(m_ext),
        .a(a), .b(b), .out_valid(out_valid), .result(result), .zero(zero),
        .operation(operation), .illegal(illegal), .busy(busy)
    );

    alu_ctrl_exec #(.WIDTH(W), .RADIX_BITS(1), .MUL_EN(0)) dut_nomul (
        .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid),
        .in_ready(n_in_ready), .alu_op(alu_op), .funct(funct), .m_ext(m_ext),
        .a(a), .b(b), .out_valid(n_out_valid), .result(n_result), .zero(n_zero),
        .operation(n_operation), .illegal(n_illegal), .busy(n_busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic model_decode(input logic [1:0] aop, input logic [3:0] f, input logic mx,
                                output logic [3:0] op, output logic ill);
        op = 4'b0000;
        ill = 1'b0;
        if (aop == 2'b00) op = 4'b0010;
        else if (aop == 2'b01) op = 4'b0110;
        else if (aop == 2'b10 && mx) begin
            if (f == 4'b0000) op = 4'b1001; else ill = 1'b1;
        end else if (aop == 2'b10) begin
            case (f)
                4'b0000: op = 4'b0010;  4'b1000: op = 4'b0110;
                4'b0111: op = 4'b0000;  4'b0110: op = 4'b0001;
                4'b0100: op = 4'b0011;  4'b0001: op = 4'b1111;
                4'b0101: op = 4'b0100;  4'b1101: op = 4'b0101;
                4'b0010: op = 4'b0111;  4'b0011: op = 4'b1000;
                default: ill = 1'b1;
            endcase
        end else begin
            case (f[2:0])
                3'b000: op = 4'b0010;  3'b111: op = 4'b0000;
                3'b110: op = 4'b0001;  3'b100: op = 4'b0011;
                3'b001: op = 4'b1111;  3'b010: op = 4'b0111;
                3'b011: op = 4'b1000;
                default: op = f[3] ? 4'b0101 : 4'b0100;
            endcase
        end
    endtask

    function automatic logic [63:0] model_calc(input logic [3:0] op, input logic [63:0] x, input logic [63:0] y);
        int sh;
        sh = int'(y % 64);
        case (op)
            4'b0010: return x + y;
            4'b0110: return x - y;
            4'b0000: return x & y;
            4'b0001: return x | y;
            4'b0011: return x ^ y;
            4'b1111: return x << sh;
            4'b0100: return x >> sh;
            4'b0101: return $signed(x) >>> sh;
            4'b0111: return ($signed(x) < $signed(y)) ? 64'd1 : 64'd0;
            4'b1000: return (x < y) ? 64'd1 : 64'd0;
            default: return x * y;
        endcase
    endfunction

    logic          m_init = 1'b0;
    logic          m_valid = 1'b0;
    logic [63:0]   m_res, m_mul;
    logic          m_zero, m_ill;
    logic [3:0]    m_op;
    int            m_left = 0;

    // Model advances on the same edge as the DUT (inputs are stable there).
    always @(posedge clk) begin
        logic [3:0] op;
        logic       ill;
        m_valid = 1'b0;
        if (reset) begin
            m_init = 1'b1; m_left = 0; m_res = '0; m_zero = 1'b0; m_op = '0; m_ill = 1'b0;
        end else if (flush) begin
            m_left = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin
                m_valid = 1'b1; m_res = m_mul; m_zero = (m_mul == 0); m_op = 4'b1001; m_ill = 1'b0;
            end
        end else if (in_valid) begin
            model_decode(alu_op, funct, m_ext, op, ill);
            if (!ill && op == 4'b1001) begin
                m_left = N;
                m_mul = a * b;
            end else begin
                m_valid = 1'b1;
                m_op = op;
                m_ill = ill;
                m_res = ill ? 64'd0 : model_calc(op, a, b);
                m_zero = (m_res == 0);
            end
        end
    end

    // Compare the DUT against the model on every cycle.
    always @(negedge clk) begin
        if (m_init) begin
            chk("out_valid", out_valid, m_valid);
            chk("in_ready", in_ready, m_left == 0);
            chk("busy", busy, m_left != 0);
            if (m_valid) begin
                $display("txn t=%0t result=%h zero=%b op=%b illegal=%b", $time, result, zero, operation, illegal);
                chk("result", result, m_res);
                chk("zero", zero, m_zero);
                chk("illegal", illegal, m_ill);
                if (!m_ill) chk("operation", operation, m_op);
            end
        end
    end

    // ---------------- stimulus ----------------
    typedef struct {
        logic [1:0]  aop;
        logic [3:0]  f;
        logic        mx;
        logic [63:0] x;
        logic [63:0] y;
        logic [63:0] r;
        logic [3:0]  op;
    } vec_t;

    localparam int NV = 19;
    vec_t vecs [NV] = '{
        '{2'b00, 4'hF,    1'b0, 64'd10, 64'd20, 64'd30, 4'b0010},
        '{2'b01, 4'h0,    1'b0, 64'd3, 64'd5, 64'hFFFFFFFFFFFFFFFE, 4'b0110},
        '{2'b10, 4'b0111, 1'b0, 64'hF0F0, 64'hFF00, 64'hF000, 4'b0000},
        '{2'b10, 4'b0110, 1'b0, 64'hF0F0, 64'hFF00, 64'hFFF0, 4'b0001},
        '{2'b10, 4'b0100, 1'b0, 64'hF0F0, 64'hFF00, 64'h0FF0, 4'b0011},
        '{2'b10, 4'b0001, 1'b0, 64'd1, 64'h43, 64'd8, 4'b1111},
        '{2'b10, 4'b0101, 1'b0, 64'h8000000000000000, 64'd63, 64'd1, 4'b0100},
        '{2'b10, 4'b0010, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'd1, 64'd1, 4'b0111},
        '{2'b10, 4'b0011, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'd1, 64'd0, 4'b1000},
        '{2'b10, 4'b0000, 1'b0, 64'hFFFFFFFFFFFFFFFF, 64'd1, 64'd0, 4'b0010},
        '{2'b11, 4'b1000, 1'b0, 64'd7, 64'd8, 64'd15, 4'b0010},
        '{2'b11, 4'b0101, 1'b0, 64'h8000000000000000, 64'd4, 64'h0800000000000000, 4'b0100},
        '{2'b11, 4'b1010, 1'b0, 64'd1, 64'd2, 64'd1, 4'b0111},
        '{2'b11, 4'b0011, 1'b0, 64'd2, 64'd1, 64'd0, 4'b1000},
        '{2'b11, 4'b0111, 1'b0, 64'hC, 64'hA, 64'h8, 4'b0000},
        '{2'b11, 4'b0110, 1'b0, 64'hC, 64'hA, 64'hE, 4'b0001},
        '{2'b11, 4'b0100, 1'b0, 64'hC, 64'hA, 64'h6, 4'b0011},
        '{2'b11, 4'b0001, 1'b0, 64'd1, 64'd63, 64'h8000000000000000, 4'b1111},
        '{2'b10, 4'b1101, 1'b0, 64'h8000000000000000, 64'd63, 64'hFFFFFFFFFFFFFFFF, 4'b0101}
    };

    task automatic issue(input logic [1:0] aop, input logic [3:0] f, input logic mx,
                         input logic [63:0] x, input logic [63:0] y);
        in_valid = 1'b1; alu_op = aop; funct = f; m_ext = mx; a = x; b = y;
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cnt;
        int seen;
        reset = 1'b1; flush = 1'b0;
        issue(2'b00, 4'h0, 1'b0, 64'd1, 64'd1);

        // Reset held two cycles with in_valid asserted.
        repeat (2) begin
            @(posedge clk); @(negedge clk);
            chk("rst_out_valid", out_valid, 1'b0);
            chk("rst_result", result, 64'd0);
            chk("rst_zero", zero, 1'b0);
            chk("rst_operation", operation, 4'b0000);
            chk("rst_illegal", illegal, 1'b0);
            chk("rst_busy", busy, 1'b0);
            chk("rst_in_ready", in_ready, 1'b1);
        end
        reset = 1'b0; idle();
        @(posedge clk); #1;
        chk("post_rst_in_ready", in_ready, 1'b1);

        // R-type SUB 5-7.
        issue(2'b10, 4'b1000, 1'b0, 64'd5, 64'd7);
        @(posedge clk); #1 idle();
        @(negedge clk);
        chk("sub_valid", out_valid, 1'b1);
        chk("sub_result", result, 64'hFFFFFFFFFFFFFFFE);
        chk("sub_op", operation, 4'b0110);
        chk("sub_zero", zero, 1'b0);

        // Back-to-back: branch-sub 9-9 then SRAI.
        @(posedge clk); #1 issue(2'b01, 4'h0, 1'b0, 64'd9, 64'd9);
        @(posedge clk); #1 issue(2'b11, 4'b1101, 1'b0, 64'h8000000000000000, 64'h44);
        @(negedge clk);
        chk("b2b1_valid", out_valid, 1'b1);
        chk("b2b1_result", result, 64'd0);
        chk("b2b1_zero", zero, 1'b1);
        @(posedge clk); #1 idle();
        @(negedge clk);
        chk("b2b2_valid", out_valid, 1'b1);
        chk("b2b2_result", result, 64'hF800000000000000);
        chk("b2b2_op", operation, 4'b0101);

        // MUL 6*7 with an ADD held pending during busy.
        @(posedge clk); #1 issue(2'b10, 4'b0000, 1'b1, 64'd6, 64'd7);
        @(posedge clk); #1 issue(2'b00, 4'h0, 1'b0, 64'd3, 64'd4);
        cnt = 0;
        while (cnt < 200) begin
            @(negedge clk); cnt++;
            if (out_valid) break;
        end
        chk("mul_latency", cnt, 65);
        chk("mul_result", result, 64'd42);
        chk("mul_op", operation, 4'b1001);
        @(posedge clk); #1 idle();
        @(negedge clk);
        chk("held_add_valid", out_valid, 1'b1);
        chk("held_add_result", result, 64'd7);

        // MUL flushed on its 10th cycle.
        @(posedge clk); #1 issue(2'b10, 4'b0000, 1'b1, 64'hFFFFFFFFFFFFFFFF, 64'd2);
        @(posedge clk); #1 idle();
        repeat (9) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        @(negedge clk);
        chk("flush_in_ready", in_ready, 1'b1);
        chk("flush_busy", busy, 1'b0);
        chk("flush_result_hold", result, 64'd7);
        seen = 0;
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("flush_no_valid", seen, 0);
        @(posedge clk); #1 issue(2'b00, 4'h0, 1'b0, 64'd1, 64'd1);
        @(posedge clk); #1 idle();
        @(negedge clk);
        chk("after_flush_add", result, 64'd2);

        // Op presented together with flush is not accepted.
        @(posedge clk); #1 flush = 1'b1; issue(2'b00, 4'h0, 1'b0, 64'd5, 64'd5);
        @(posedge clk); #1 flush = 1'b0; idle();
        @(negedge clk);
        chk("flush_accept_valid", out_valid, 1'b0);
        chk("flush_accept_result", result, 64'd2);

        // Illegal encodings.
        @(posedge clk); #1 issue(2'b10, 4'b1010, 1'b0, 64'd3, 64'd3);
        @(posedge clk); #1 issue(2'b10, 4'b0001, 1'b1, 64'd3, 64'd3);
        @(negedge clk);
        chk("ill_valid", out_valid, 1'b1);
        chk("ill_flag", illegal, 1'b1);
        chk("ill_result", result, 64'd0);
        chk("ill_zero", zero, 1'b1);
        @(posedge clk); #1 idle();
        @(negedge clk);
        chk("ill_mext_flag", illegal, 1'b1);

        // Directed vectors issued back-to-back.
        @(posedge clk); #1 issue(vecs[0].aop, vecs[0].f, vecs[0].mx, vecs[0].x, vecs[0].y);
        for (int i = 0; i < NV; i++) begin
            @(posedge clk); #1;
            if (i + 1 < NV) issue(vecs[i+1].aop, vecs[i+1].f, vecs[i+1].mx, vecs[i+1].x, vecs[i+1].y);
            else idle();
            @(negedge clk);
            chk($sformatf("vec%0d_valid", i), out_valid, 1'b1);
            chk($sformatf("vec%0d_result", i), result, vecs[i].r);
            chk($sformatf("vec%0d_op", i), operation, vecs[i].op);
            chk($sformatf("vec%0d_zero", i), zero, vecs[i].r == 64'd0);
        end

        // MUL request on the MUL_EN=0 instance decodes as illegal.
        @(posedge clk); #1 issue(2'b10, 4'b0000, 1'b1, 64'd6, 64'd7);
        @(posedge clk); #1 idle();
        @(negedge clk);
        chk("nomul_valid", n_out_valid, 1'b1);
        chk("nomul_illegal", n_illegal, 1'b1);
        chk("nomul_result", n_result, 64'd0);
        chk("nomul_zero", n_zero, 1'b1);
        chk("nomul_busy", n_busy, 1'b0);
        chk("mul_busy", busy, 1'b1);
        cnt = 0;
        while (cnt < 200) begin
            @(negedge clk); cnt++;
            if (out_valid) break;
        end
        chk("mul2_latency", cnt, 64);
        chk("mul2_result", result, 64'd42);

        // Reset in the middle of a MUL.
        @(posedge clk); #1 issue(2'b10, 4'b0000, 1'b1, 64'd3, 64'd3);
        @(posedge clk); #1 idle();
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_in_ready", in_ready, 1'b1);
        chk("midrst_result", result, 64'd0);
        chk("midrst_valid", out_valid, 1'b0);
        repeat (70) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
